// File: rtl/sprite_render_if.sv
// Sprite draw/erase handshake plus the shared VGA plot port.
// master = render sequencer; slave = sprite blocks and VGA adapter side.
interface sprite_render_if #(
    parameter int unsigned NUM_SPRITES = 4
);
    logic [NUM_SPRITES-1:0]   draw_signal;
    logic [NUM_SPRITES-1:0]   erase_signal;
    logic [NUM_SPRITES-1:0]   finish;
    logic [9*NUM_SPRITES-1:0] sprite_x;
    logic [8*NUM_SPRITES-1:0] sprite_y;
    logic [3*NUM_SPRITES-1:0] sprite_colour;
    logic [8:0]               vga_x;
    logic [7:0]               vga_y;
    logic [2:0]               vga_colour;
    logic                     vga_plot;

    modport master (
        output draw_signal, erase_signal, vga_x, vga_y, vga_colour, vga_plot,
        input  finish, sprite_x, sprite_y, sprite_colour
    );

    modport slave (
        input  draw_signal, erase_signal, vga_x, vga_y, vga_colour, vga_plot,
        output finish, sprite_x, sprite_y, sprite_colour
    );
endinterface

// File: rtl/sprite_render_sequencer.sv
// Frame-level sequencer: each frame tick, erases then redraws every sprite in
// index order and muxes the active sprite onto the single VGA plot port.
module sprite_render_sequencer #(
    parameter int unsigned NUM_SPRITES  = 4,
    parameter int unsigned FRAME_DIV    = 833333,
    parameter int unsigned ERASE_CYCLES = 44,
    parameter int unsigned SETUP_CYCLES = 3,
    parameter int unsigned DRAW_TIMEOUT = 64,
    localparam int unsigned ID_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic            clk,
    input  logic            reset,
    sprite_render_if.master bus,
    output logic            frame_tick,
    output logic            busy,
    output logic [ID_W-1:0] active_id,
    output logic            draw_timeout,
    output logic            frame_overrun
);
    localparam int unsigned DIV_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned PHASE_MAX = (ERASE_CYCLES > DRAW_TIMEOUT) ? ERASE_CYCLES : DRAW_TIMEOUT;
    localparam int unsigned CNT_W     = $clog2(PHASE_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(FRAME_DIV - 1);
    localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAW_LAST  = CNT_W'(DRAW_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETUP_CNT  = CNT_W'(SETUP_CYCLES);
    localparam logic [ID_W-1:0]  ID_LAST    = ID_W'(NUM_SPRITES - 1);
    localparam logic             ENTRY_PLOT = (SETUP_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        NEXT  = 2'd3
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] phase_cnt;
    logic             pending;
    logic             plot_q;

    logic [CNT_W-1:0] phase_inc;
    logic [ID_W-1:0]  id_inc;
    logic             finish_hit;

    function automatic logic [NUM_SPRITES-1:0] one_hot(input logic [ID_W-1:0] id);
        return NUM_SPRITES'(1) << id;
    endfunction

    assign phase_inc  = phase_cnt + CNT_W'(1);
    assign id_inc     = active_id + ID_W'(1);
    assign finish_hit = (state == DRAW) && bus.finish[active_id];

    // Active sprite's fields straight onto the VGA port; plot is masked the cycle finish lands.
    assign bus.vga_x      = bus.sprite_x[9*int'(active_id) +: 9];
    assign bus.vga_y      = bus.sprite_y[8*int'(active_id) +: 8];
    assign bus.vga_colour = bus.sprite_colour[3*int'(active_id) +: 3];
    assign bus.vga_plot   = plot_q & ~finish_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            div_cnt          <= '0;
            frame_tick       <= 1'b0;
            pending          <= 1'b0;
            frame_overrun    <= 1'b0;
            phase_cnt        <= '0;
            active_id        <= '0;
            busy             <= 1'b0;
            draw_timeout     <= 1'b0;
            plot_q           <= 1'b0;
            bus.draw_signal  <= '0;
            bus.erase_signal <= '0;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt    <= '0;
                frame_tick <= 1'b1;
            end else begin
                div_cnt    <= div_cnt + DIV_W'(1);
                frame_tick <= 1'b0;
            end

            // One-deep tick latch; a second tick before the sweep starts is dropped and flagged.
            if (frame_tick && pending) frame_overrun <= 1'b1;
            if (state == IDLE && pending) pending <= 1'b0;
            else if (frame_tick)          pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (pending) begin
                        state            <= ERASE;
                        active_id        <= '0;
                        phase_cnt        <= '0;
                        busy             <= 1'b1;
                        plot_q           <= ENTRY_PLOT;
                        bus.erase_signal <= one_hot('0);
                    end
                end
                ERASE: begin
                    if (phase_cnt == ERASE_LAST) begin
                        state            <= DRAW;
                        phase_cnt        <= '0;
                        plot_q           <= ENTRY_PLOT;
                        bus.erase_signal <= '0;
                        bus.draw_signal  <= one_hot(active_id);
                    end else begin
                        phase_cnt <= phase_inc;
                        plot_q    <= (phase_inc >= SETUP_CNT);
                    end
                end
                DRAW: begin
                    if (finish_hit || phase_cnt == DRAW_LAST) begin
                        state           <= NEXT;
                        phase_cnt       <= '0;
                        plot_q          <= 1'b0;
                        bus.draw_signal <= '0;
                        if (!finish_hit) draw_timeout <= 1'b1;
                    end else begin
                        phase_cnt <= phase_inc;
                        plot_q    <= (phase_inc >= SETUP_CNT);
                    end
                end
                NEXT: begin
                    if (active_id == ID_LAST) begin
                        state     <= IDLE;
                        active_id <= '0;
                        busy      <= 1'b0;
                    end else begin
                        state            <= ERASE;
                        active_id        <= id_inc;
                        phase_cnt        <= '0;
                        plot_q           <= ENTRY_PLOT;
                        bus.erase_signal <= one_hot(id_inc);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_render_sequencer.sv
// Directed bench: dut_a (FRAME_DIV=400) covers sweep, mux, timeout, foreign finish
// and async reset; dut_b (FRAME_DIV=60) covers tick latching and overrun.
module tb_sprite_render_sequencer;
    localparam int unsigned NS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic tick_a, busy_a, tmo_a, ovr_a;
    logic tick_b, busy_b, tmo_b, ovr_b;
    logic [0:0] id_a, id_b;

    sprite_render_if #(.NUM_SPRITES(NS)) bus_a ();
    sprite_render_if #(.NUM_SPRITES(NS)) bus_b ();

    sprite_render_sequencer #(.NUM_SPRITES(NS), .FRAME_DIV(400), .ERASE_CYCLES(44),
                              .SETUP_CYCLES(3), .DRAW_TIMEOUT(64)) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a), .frame_tick(tick_a), .busy(busy_a),
        .active_id(id_a), .draw_timeout(tmo_a), .frame_overrun(ovr_a));

    sprite_render_sequencer #(.NUM_SPRITES(NS), .FRAME_DIV(60), .ERASE_CYCLES(44),
                              .SETUP_CYCLES(3), .DRAW_TIMEOUT(64)) dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b), .frame_tick(tick_b), .busy(busy_b),
        .active_id(id_b), .draw_timeout(tmo_b), .frame_overrun(ovr_b));

    // Sprite models: finish pulses on the 45th draw cycle (44 cycles after draw rise).
    logic [NS-1:0] en_a, inj_a, fin_a, fin_b;
    logic [7:0] dcnt_a [NS];
    logic [7:0] dcnt_b [NS];

    always @(posedge clk)
        for (int i = 0; i < NS; i++) begin
            dcnt_a[i] <= bus_a.draw_signal[i] ? dcnt_a[i] + 8'd1 : 8'd0;
            dcnt_b[i] <= bus_b.draw_signal[i] ? dcnt_b[i] + 8'd1 : 8'd0;
        end

    always_comb
        for (int i = 0; i < NS; i++) begin
            fin_a[i] = (en_a[i] && bus_a.draw_signal[i] && dcnt_a[i] == 8'd44) || inj_a[i];
            fin_b[i] = bus_b.draw_signal[i] && dcnt_b[i] == 8'd44;
        end

    assign bus_a.finish        = fin_a;
    assign bus_a.sprite_x      = {9'd20, 9'd180};
    assign bus_a.sprite_y      = {8'd200, 8'd10};
    assign bus_a.sprite_colour = {3'd2, 3'd5};
    assign bus_b.finish        = fin_b;
    assign bus_b.sprite_x      = {9'd20, 9'd180};
    assign bus_b.sprite_y      = {8'd200, 8'd10};
    assign bus_b.sprite_colour = {3'd2, 3'd5};

    int total = 0;
    int bad   = 0;
    int multi_req = 0;

    always @(negedge clk)
        if ($countones({bus_a.draw_signal, bus_a.erase_signal}) > 1 ||
            $countones({bus_b.draw_signal, bus_b.erase_signal}) > 1)
            multi_req++;

    int ex_x [NS] = '{180, 20};
    int ex_y [NS] = '{10, 200};
    int ex_c [NS] = '{5, 2};

    function automatic logic [NS-1:0] sel(input int s);
        logic [NS-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    // Sweep observation results for dut_a
    int m_erase [NS];
    int m_draw  [NS];
    int m_gap, m_plot_bad, m_mux_bad;
    bit m_started, m_end_busy;

    task automatic measure_sweep();
        int n, k;
        bit exp_plot;
        m_started = 0; m_gap = 0; m_plot_bad = 0; m_mux_bad = 0; m_end_busy = 1;
        for (int s = 0; s < NS; s++) begin m_erase[s] = 0; m_draw[s] = 0; end
        n = 0;
        while (busy_a !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        if (busy_a !== 1'b1) return;
        m_started = 1;
        for (int s = 0; s < NS; s++) begin
            k = 0;
            while (bus_a.erase_signal === sel(s) && bus_a.draw_signal === '0 &&
                   id_a === 1'(s) && k < 200) begin
                exp_plot = (k >= 3);
                if (bus_a.vga_plot !== exp_plot) m_plot_bad++;
                if (bus_a.vga_x !== 9'(ex_x[s]) || bus_a.vga_y !== 8'(ex_y[s]) ||
                    bus_a.vga_colour !== 3'(ex_c[s])) m_mux_bad++;
                k++;
                @(negedge clk);
            end
            m_erase[s] = k;
            k = 0;
            while (bus_a.draw_signal === sel(s) && bus_a.erase_signal === '0 && k < 200) begin
                exp_plot = (k >= 3) && (bus_a.finish[s] !== 1'b1);
                if (bus_a.vga_plot !== exp_plot) m_plot_bad++;
                if (bus_a.vga_x !== 9'(ex_x[s]) || bus_a.vga_y !== 8'(ex_y[s]) ||
                    bus_a.vga_colour !== 3'(ex_c[s])) m_mux_bad++;
                k++;
                @(negedge clk);
            end
            m_draw[s] = k;
            if (bus_a.draw_signal === '0 && bus_a.erase_signal === '0 &&
                busy_a === 1'b1 && bus_a.vga_plot === 1'b0) m_gap++;
            @(negedge clk);
        end
        m_end_busy = busy_a;
    endtask

    task automatic test_reset();
        int n;
        rst_a = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus_a.draw_signal, bus_a.erase_signal, bus_a.vga_plot, tick_a, busy_a, tmo_a, ovr_a, id_a} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%b want=0",
                {bus_a.draw_signal, bus_a.erase_signal, bus_a.vga_plot, tick_a, busy_a, tmo_a, ovr_a, id_a});
        end
        total++;
        if (bus_a.vga_x !== 9'd180 || bus_a.vga_y !== 8'd10 || bus_a.vga_colour !== 3'd5) begin
            bad++; $display("FAIL reset_mux got=%0d/%0d/%0d want=180/10/5",
                bus_a.vga_x, bus_a.vga_y, bus_a.vga_colour);
        end
        rst_a = 1'b1;
        n = 0;
        while (tick_a !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        total++;
        if (n != 400) begin bad++; $display("FAIL first_tick got=%0d want=400", n); end
    endtask

    task automatic test_sweep();
        measure_sweep();
        total++;
        if (!m_started) begin bad++; $display("FAIL sweep_start got=0 want=1"); end
        for (int s = 0; s < NS; s++) begin
            total++;
            if (m_erase[s] != 44) begin bad++; $display("FAIL sweep_erase%0d got=%0d want=44", s, m_erase[s]); end
            total++;
            if (m_draw[s] != 45) begin bad++; $display("FAIL sweep_draw%0d got=%0d want=45", s, m_draw[s]); end
        end
        total++;
        if (m_gap != 2) begin bad++; $display("FAIL sweep_gap got=%0d want=2", m_gap); end
        total++;
        if (m_plot_bad != 0) begin bad++; $display("FAIL sweep_plot got=%0d want=0", m_plot_bad); end
        total++;
        if (m_mux_bad != 0) begin bad++; $display("FAIL sweep_mux got=%0d want=0", m_mux_bad); end
        total++;
        if (m_end_busy !== 1'b0 || tmo_a !== 1'b0) begin
            bad++; $display("FAIL sweep_end busy=%b tmo=%b want=0/0", m_end_busy, tmo_a);
        end
    endtask

    task automatic test_foreign_finish();
        bit injected;
        injected = 0;
        fork
            measure_sweep();
            begin
                int n;
                n = 0;
                while (bus_a.draw_signal !== 2'b01 && n < 1000) begin @(negedge clk); n++; end
                if (bus_a.draw_signal === 2'b01) begin
                    repeat (10) @(negedge clk);
                    inj_a = 2'b10;
                    @(negedge clk);
                    inj_a = 2'b00;
                    injected = 1;
                end
            end
        join
        total++;
        if (!injected) begin bad++; $display("FAIL foreign_inject got=0 want=1"); end
        total++;
        if (m_draw[0] != 45) begin bad++; $display("FAIL foreign_draw0 got=%0d want=45", m_draw[0]); end
        total++;
        if (m_draw[1] != 45 || tmo_a !== 1'b0) begin
            bad++; $display("FAIL foreign_draw1 got=%0d tmo=%b want=45/0", m_draw[1], tmo_a);
        end
    endtask

    task automatic test_timeout();
        en_a[1] = 1'b0;
        measure_sweep();
        total++;
        if (m_draw[1] != 64) begin bad++; $display("FAIL timeout_draw1 got=%0d want=64", m_draw[1]); end
        total++;
        if (m_draw[0] != 45 || m_erase[1] != 44) begin
            bad++; $display("FAIL timeout_other got=%0d/%0d want=45/44", m_draw[0], m_erase[1]);
        end
        total++;
        if (tmo_a !== 1'b1 || m_plot_bad != 0) begin
            bad++; $display("FAIL timeout_flag got=%b plot_bad=%0d want=1/0", tmo_a, m_plot_bad);
        end
        en_a[1] = 1'b1;
        measure_sweep();
        total++;
        if (!m_started || m_draw[0] != 45 || m_draw[1] != 45) begin
            bad++; $display("FAIL timeout_next_frame got=%0d/%0d/%0d want=1/45/45",
                m_started, m_draw[0], m_draw[1]);
        end
        total++;
        if (tmo_a !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b want=1", tmo_a); end
    endtask

    task automatic test_midreset();
        int n;
        n = 0;
        while (bus_a.draw_signal !== 2'b10 && n < 1000) begin @(negedge clk); n++; end
        total++;
        if (bus_a.draw_signal !== 2'b10) begin
            bad++; $display("FAIL midreset_reach got=%b want=10", bus_a.draw_signal);
        end
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rst_a = 1'b0;
        #1;
        total++;
        if ({bus_a.draw_signal, bus_a.erase_signal, bus_a.vga_plot, busy_a, tmo_a, ovr_a} !== '0) begin
            bad++; $display("FAIL midreset_clear got=%b want=0",
                {bus_a.draw_signal, bus_a.erase_signal, bus_a.vga_plot, busy_a, tmo_a, ovr_a});
        end
        @(negedge clk);
        rst_a = 1'b1;
        n = 0;
        while (tick_a !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        total++;
        if (n != 400) begin bad++; $display("FAIL midreset_tick got=%0d want=400", n); end
    endtask

    task automatic test_overrun();
        @(negedge clk);
        rst_b = 1'b1;
        for (int n = 1; n <= 250; n++) begin
            @(negedge clk);
            case (n)
                60: begin total++;
                    if (tick_b !== 1'b1) begin bad++; $display("FAIL ovr_tick60 got=%b want=1", tick_b); end end
                61: begin total++;
                    if (busy_b !== 1'b0) begin bad++; $display("FAIL ovr_busy61 got=%b want=0", busy_b); end end
                62: begin total++;
                    if (busy_b !== 1'b1 || bus_b.erase_signal !== 2'b01) begin
                        bad++; $display("FAIL ovr_start62 got=%b/%b want=1/01", busy_b, bus_b.erase_signal); end end
                120: begin total++;
                    if (tick_b !== 1'b1 || busy_b !== 1'b1 || ovr_b !== 1'b0) begin
                        bad++; $display("FAIL ovr_tick120 got=%b%b%b want=110", tick_b, busy_b, ovr_b); end end
                180: begin total++;
                    if (ovr_b !== 1'b0) begin bad++; $display("FAIL ovr_pre181 got=%b want=0", ovr_b); end end
                181: begin total++;
                    if (ovr_b !== 1'b1) begin bad++; $display("FAIL ovr_set181 got=%b want=1", ovr_b); end end
                241: begin total++;
                    if (busy_b !== 1'b1) begin bad++; $display("FAIL ovr_busy241 got=%b want=1", busy_b); end end
                242: begin total++;
                    if (busy_b !== 1'b0) begin bad++; $display("FAIL ovr_idle242 got=%b want=0", busy_b); end end
                243: begin total++;
                    if (busy_b !== 1'b1 || bus_b.erase_signal !== 2'b01 || ovr_b !== 1'b1) begin
                        bad++; $display("FAIL ovr_restart243 got=%b/%b/%b want=1/01/1",
                            busy_b, bus_b.erase_signal, ovr_b); end end
                default: ;
            endcase
        end
    endtask

    task automatic test_one_hot();
        total++;
        if (multi_req != 0) begin bad++; $display("FAIL one_hot got=%0d want=0", multi_req); end
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        en_a  = '1;
        inj_a = '0;
        test_reset();
        test_sweep();
        test_foreign_finish();
        test_timeout();
        test_midreset();
        test_overrun();
        test_one_hot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
